// File: rtl/comb_lock_pkg.sv
// Shared types and default-build constants for the parametrised combination lock.
package comb_lock_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StOpen,
    StProgram,
    StLocked
  } state_e;

  localparam int unsigned DefDigitW     = 4;
  localparam int unsigned DefCodeLen    = 4;
  localparam int unsigned DefMaxTries   = 3;
  localparam int unsigned DefLockCycles = 22;

  // First digit lives in the most significant slice.
  localparam logic [DefDigitW*DefCodeLen-1:0] DefaultCode = {4'd1, 4'd5, 4'd3, 4'd7};

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned FailCntW = cnt_width(DefMaxTries);
  localparam int unsigned LockCntW = cnt_width(DefLockCycles);

endpackage

// File: rtl/comb_lock_param_lock_timer.sv
// Lockout down-counter: loads CYCLES on start, active while non-zero, expired on the last cycle.
module lock_timer
  import comb_lock_pkg::*;
#(
  parameter int unsigned CYCLES = DefLockCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic active,
  output logic expired
);

  localparam int unsigned CntW = cnt_width(CYCLES);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= CntW'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign active  = (cnt_q != '0);
  assign expired = (cnt_q == CntW'(1));

endmodule

// File: rtl/comb_lock_param.sv
// Parametrised combination lock with strobed digit entry, attempt lockout and code reprogramming.
module comb_lock_param
  import comb_lock_pkg::*;
#(
  parameter int unsigned DIGIT_W     = DefDigitW,
  parameter int unsigned CODE_LEN    = DefCodeLen,
  parameter int unsigned MAX_TRIES   = DefMaxTries,
  parameter int unsigned LOCK_CYCLES = DefLockCycles,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = DefaultCode,
  localparam int unsigned FailW = cnt_width(MAX_TRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enter_button,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               prog_req,
  output logic               grant,
  output logic               deny,
  output logic               lock,
  output logic               prog_done,
  output logic               busy,
  output logic [FailW-1:0]   fail_count
);

  localparam int unsigned CodeW = DIGIT_W * CODE_LEN;
  localparam int unsigned IdxW  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(CODE_LEN - 1);
  localparam logic [FailW-1:0] FailMax = FailW'(MAX_TRIES);

  state_e             state_q;
  logic [IdxW-1:0]    idx_q;
  logic               mismatch_q;
  logic [CodeW-1:0]   code_q;
  logic [CodeW-1:0]   shadow_q;
  logic [CodeW-1:0]   shadow_d;
  logic [FailW-1:0]   fail_q;
  logic               grant_q;
  logic               deny_q;
  logic               prog_done_q;

  logic [DIGIT_W-1:0] cur_digit;
  logic [FailW-1:0]   fail_inc;
  logic               last_digit;
  logic               mismatch_d;
  logic               lock_start;
  logic               timer_active;
  logic               timer_expired;

  // Select the stored digit at the current index and merge the incoming digit into the shadow.
  always_comb begin
    cur_digit = '0;
    shadow_d  = shadow_q;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_digit = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        shadow_d[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
      end
    end
  end

  assign last_digit = (idx_q == LastIdx);
  assign mismatch_d = mismatch_q | (digit != cur_digit);
  assign fail_inc   = (fail_q == FailMax) ? fail_q : fail_q + 1'b1;
  assign lock_start = (state_q == StEntry) && !enter_button && digit_valid && last_digit &&
                      mismatch_d && (fail_inc == FailMax);

  lock_timer #(
    .CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (lock_start),
    .active  (timer_active),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      mismatch_q  <= 1'b0;
      code_q      <= DEFAULT_CODE;
      shadow_q    <= '0;
      fail_q      <= '0;
      grant_q     <= 1'b0;
      deny_q      <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      grant_q     <= 1'b0;
      deny_q      <= 1'b0;
      prog_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enter_button) begin
            state_q    <= StEntry;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
          end
        end
        StEntry: begin
          // A restart takes priority over a digit presented in the same cycle.
          if (enter_button) begin
            idx_q      <= '0;
            mismatch_q <= 1'b0;
          end else if (digit_valid) begin
            if (last_digit) begin
              idx_q      <= '0;
              mismatch_q <= 1'b0;
              if (!mismatch_d) begin
                grant_q <= 1'b1;
                fail_q  <= '0;
                state_q <= StOpen;
              end else begin
                deny_q  <= 1'b1;
                fail_q  <= fail_inc;
                state_q <= (fail_inc == FailMax) ? StLocked : StIdle;
              end
            end else begin
              idx_q      <= idx_q + 1'b1;
              mismatch_q <= mismatch_d;
            end
          end
        end
        StOpen: begin
          idx_q   <= '0;
          state_q <= prog_req ? StProgram : StIdle;
        end
        StProgram: begin
          if (enter_button) begin
            idx_q   <= '0;
            state_q <= StIdle;
          end else if (digit_valid) begin
            shadow_q <= shadow_d;
            if (last_digit) begin
              code_q      <= shadow_d;
              prog_done_q <= 1'b1;
              idx_q       <= '0;
              state_q     <= StIdle;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StLocked: begin
          if (timer_expired) begin
            fail_q  <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant      = grant_q;
  assign deny       = deny_q;
  assign lock       = timer_active;
  assign prog_done  = prog_done_q;
  assign busy       = (state_q == StEntry) || (state_q == StProgram);
  assign fail_count = fail_q;

endmodule

// File: tb/tb_comb_lock_param.sv
// Directed, table-driven bench for comb_lock_param in its default build.
module tb_comb_lock_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       enter_button;
  logic       digit_valid;
  logic [3:0] digit;
  logic       prog_req;
  logic       grant;
  logic       deny;
  logic       lock;
  logic       prog_done;
  logic       busy;
  logic [1:0] fail_count;

  comb_lock_param dut (
    .clk          (clk),
    .rst          (rst),
    .enter_button (enter_button),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .prog_req     (prog_req),
    .grant        (grant),
    .deny         (deny),
    .lock         (lock),
    .prog_done    (prog_done),
    .busy         (busy),
    .fail_count   (fail_count)
  );

  always #5 clk = ~clk;

  // exp = {grant, deny, lock, prog_done, busy, fail_count[1:0]} after the clock edge.
  typedef struct {
    logic       en;
    logic       dv;
    logic [3:0] d;
    logic       pr;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   lock_len;

  function automatic void push(input logic en, input logic dv, input logic [3:0] d,
                               input logic pr, input logic g, input logic dn, input logic lk,
                               input logic pd, input logic bz, input logic [1:0] fc);
    vec_t v;
    v.en  = en;
    v.dv  = dv;
    v.d   = d;
    v.pr  = pr;
    v.exp = {g, dn, lk, pd, bz, fc};
    vecs.push_back(v);
  endfunction

  // One full entry of a 4-digit code (hex nibbles) plus the following cycle.
  function automatic void entry(input logic [15:0] code, input logic ok, input logic [1:0] fc,
                                input logic pr);
    logic [1:0] nf;
    logic       lk;
    nf = ok ? 2'd0 : fc + 2'd1;
    lk = !ok && (nf == 2'd3);
    push(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fc);
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 1'b1, 4'(code >> (12 - 4*i)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fc);
    end
    push(1'b0, 1'b1, code[3:0], 1'b0, ok, !ok, lk, 1'b0, 1'b0, nf);
    push(1'b0, 1'b0, 4'd0, pr, 1'b0, 1'b0, lk, 1'b0, pr & ok, nf);
  endfunction

  task automatic chk(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {grant, deny, lock, prog_done, busy, fail_count};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got g/d/l/pd/b/fc=%b want %b", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic apply(input logic en, input logic dv, input logic [3:0] d, input logic pr);
    @(negedge clk);
    enter_button = en;
    digit_valid  = dv;
    digit        = d;
    prog_req     = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_queue(input string tag);
    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].dv, vecs[i].d, vecs[i].pr);
      chk($sformatf("%s[%0d]", tag, i), vecs[i].exp);
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    enter_button = 1'b0;
    digit_valid  = 1'b0;
    digit        = 4'd0;
    prog_req     = 1'b0;
    #1;
    chk("reset", 7'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Correct default code.
    entry(16'h1537, 1'b1, 2'd0, 1'b0);
    // digit_valid in IDLE is ignored.
    push(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    entry(16'h1537, 1'b1, 2'd0, 1'b0);
    // Two failures then a success clears the count.
    entry(16'h2000, 1'b0, 2'd0, 1'b0);
    entry(16'h1111, 1'b0, 2'd1, 1'b0);
    entry(16'h1537, 1'b1, 2'd2, 1'b0);
    // Restart after two digits is not a failure.
    entry(16'h2000, 1'b0, 2'd0, 1'b0);
    push(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    push(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    push(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    entry(16'h0000, 1'b0, 2'd1, 1'b0);
    entry(16'h1537, 1'b1, 2'd2, 1'b0);
    // enter_button with digit_valid: restart wins, digit dropped.
    push(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    // Reprogram to 9,9,0,2.
    entry(16'h1537, 1'b1, 2'd0, 1'b1);
    push(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    entry(16'h1537, 1'b0, 2'd0, 1'b0);
    entry(16'h9902, 1'b1, 2'd1, 1'b0);
    // Abort programming after two digits: code unchanged.
    entry(16'h9902, 1'b1, 2'd0, 1'b1);
    push(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    entry(16'h9902, 1'b1, 2'd0, 1'b0);
    run_queue("table");

    // Lockout: three failures, lock high for exactly 22 cycles with enter_button held.
    entry(16'h2000, 1'b0, 2'd0, 1'b0);
    entry(16'h1111, 1'b0, 2'd1, 1'b0);
    entry(16'h0000, 1'b0, 2'd2, 1'b0);
    run_queue("lockout");
    lock_len = 2;
    for (int k = 0; k < 40; k++) begin
      apply(1'b1, 1'b0, 4'd0, 1'b0);
      if (lock === 1'b1) lock_len++;
      else break;
    end
    chk_int("lock_len", lock_len, 22);
    chk("lock_exit", 7'b0);
    apply(1'b1, 1'b0, 4'd0, 1'b0);
    chk("enter_after_lock", 7'b0000100);
    push(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    push(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    push(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    run_queue("post_lock");

    // Reset in the 10th lock cycle clears everything and restores the default code.
    entry(16'h2000, 1'b0, 2'd0, 1'b0);
    entry(16'h1111, 1'b0, 2'd1, 1'b0);
    entry(16'h0000, 1'b0, 2'd2, 1'b0);
    run_queue("relock");
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b0, 4'd0, 1'b0);
      chk($sformatf("lock_hold[%0d]", k), 7'b0010011);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_lock", 7'b0);
    @(negedge clk);
    rst = 1'b0;
    entry(16'h9902, 1'b0, 2'd0, 1'b0);
    entry(16'h1537, 1'b1, 2'd1, 1'b0);
    run_queue("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/comb_lock_param.md
Name: comb_lock_param

Overview:
Parametrised successor to the fixed 4-digit combination lock. Digit width, code length, attempt limit and lockout duration are all configurable. The stored code is reprogrammable after a successful entry. Entry uses an explicit digit-valid strobe rather than per-cycle sampling. It sits between keypad debounce/decode logic and the door actuator / status LEDs.

Parameters:
DIGIT_W, 4, bits per entered digit
CODE_LEN, 4, digits per code
MAX_TRIES, 3, consecutive failed attempts that trigger lockout (>=1)
LOCK_CYCLES, 22, clock cycles lock stays asserted (>=1)
DEFAULT_CODE, {4'd1,4'd5,4'd3,4'd7}, reset code, DIGIT_W*CODE_LEN bits, first digit in MS slice

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
enter_button  in  1  start (or restart) a code entry
digit_valid  in  1  digit is presented this cycle
digit  in  DIGIT_W  entered digit value
prog_req  in  1  request code change; sampled only in the grant cycle
grant  out  1  one-cycle pulse, code matched
deny  out  1  one-cycle pulse, code mismatched
lock  out  1  high throughout lockout
prog_done  out  1  one-cycle pulse, new code committed
busy  out  1  high in ENTRY or PROGRAM
fail_count  out  $clog2(MAX_TRIES+1)  consecutive failures so far

Behaviour:
- Reset (async): state IDLE; all outputs 0; fail_count 0; code register = DEFAULT_CODE; digit index 0; mismatch flag 0.
- States: IDLE, ENTRY, OPEN, PROGRAM, LOCKED.
- IDLE: enter_button=1 -> ENTRY with index 0 and mismatch cleared. digit_valid is ignored.
- ENTRY: on each digit_valid, compare digit against code slice[index] and OR any difference into mismatch; then index++.
- ENTRY completion: the cycle after the CODE_LEN-th digit is accepted, the result is registered:
  - Match -> OPEN: grant=1 for 1 cycle; fail_count cleared.
  - Mismatch: deny=1 for 1 cycle; fail_count++.
    - If the new fail_count == MAX_TRIES -> LOCKED, and lock rises in the same cycle as deny.
    - Otherwise -> IDLE.
- enter_button during ENTRY restarts entry (index 0, mismatch cleared). A restart is not counted as a failure. If enter_button and digit_valid arrive in the same cycle, enter_button wins and the digit is dropped.
- OPEN (1 cycle): prog_req=1 -> PROGRAM (index 0); otherwise -> IDLE.
- PROGRAM: digit_valid digits load into a shadow register at slice[index]. After CODE_LEN digits, the shadow is copied to the code register and prog_done pulses for 1 cycle in the next cycle; then -> IDLE. enter_button during PROGRAM aborts: code unchanged, no prog_done, -> IDLE.
- LOCKED: lock=1 for exactly LOCK_CYCLES cycles, counted from its first high cycle. All inputs are ignored. On expiry: lock=0, fail_count=0, -> IDLE. enter_button is first accepted in the cycle lock is low.
- fail_count saturates at MAX_TRIES and is never observed above it.
- grant, deny and prog_done are mutually exclusive.
- busy = state is ENTRY or PROGRAM.
- Reset mid-ENTRY, mid-PROGRAM or mid-LOCKED: immediate return to reset values, including DEFAULT_CODE.

Decomposition:
- Package comb_lock_pkg: state enum, widths for the fail counter and lock counter, and the DEFAULT_CODE constant for the default build.
- One sub-module, lock_timer: load/enable down-counter of width $clog2(LOCK_CYCLES+1). Inputs: start. Outputs: active, expired (1-cycle pulse).

Test Plan:
- Reset, then enter_button and digits 1,5,3,7 via digit_valid -> grant pulses 1 cycle after the digit 7 cycle; deny=0; fail_count=0.
- Three entries 2,0,0,0 / 1,1,1,1 / 0,0,0,0 -> deny on each, fail_count 1,2,3; lock rises with the third deny and stays high exactly 22 cycles; then fail_count=0 and 1,5,3,7 grants.
- Two wrong entries followed by 1,5,3,7 -> grant and fail_count returns to 0; a further three wrong entries are needed to lock.
- Correct entry with prog_req=1 in the grant cycle, then digits 9,9,0,2 -> prog_done pulses; 1,5,3,7 now denies; 9,9,0,2 grants.
- enter_button after digits 1,5 then 1,5,3,7 -> single grant, fail_count unchanged. enter_button during PROGRAM after 2 digits -> no prog_done, old code still works.
- Assert rst during LOCKED at cycle 10 -> lock=0 immediately, fail_count=0; after a reprogram, rst restores code 1,5,3,7.
